tone_detector: RTL and testbench
================================

TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 Parameters (name, default, meaning):
- CONFIRM, 4: consecutive matching half-periods needed to declare a note.
- TOL, 512: inclusive match window in clk cycles, plus or minus around each reference half-period.
- TIMEOUT, 120_000: clk cycles without a tone_in edge before the tone is declared silent.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: sole clock, 50 MHz.
- rst, in, 1: synchronous, active-high reset.
- tone_in, in, 1: asynchronous square-wave melody input.
- note, out, 3: detected note; 0 = none, 1 = do, 2 = re, 3 = mi, 4 = fa, 5 = si.
- octave, out, 1: 0 = high table, 1 = low table.
- note_valid, out, 1: a confirmed note is present.
- note_changed, out, 1: single-cycle pulse whenever {note_valid, note, octave} changes.

Function
REQ-003 tone_in SHALL pass through a 2-flop synchronizer followed by an edge detector; both rising and falling edges count as edges.
REQ-004 The measured half-period SHALL be the number of clk cycles between two consecutive detected edges; the counter is 17 bits and saturates at TIMEOUT.
REQ-005 The first edge after reset or after a timeout SHALL only arm the measurement; no period is evaluated on that edge.
REQ-006 High-table reference half-periods SHALL be: do 47_779, re 42_567, mi 37_923, fa 35_794, si 50_620.
REQ-007 Low-table reference half-periods SHALL be: do 95_557, re 85_132, mi 75_844, fa 71_588, si 101_239.
REQ-008 A period SHALL match an entry when |period - ref| <= TOL; the windows do not overlap at the default TOL.
REQ-009 On each evaluated period, a match equal to the current candidate SHALL increment the run count, saturating at CONFIRM.
REQ-010 On each evaluated period, a match different from the current candidate SHALL set that entry as the new candidate with run count 1.
REQ-011 When the run count reaches CONFIRM and the candidate differs from the outputs (or note_valid is 0), the block SHALL load note/octave, set note_valid = 1, and pulse note_changed on the next cycle.
REQ-012 A matched but different period SHALL NOT disturb the current outputs until the new candidate is confirmed.
REQ-013 An unmatched period SHALL clear the candidate and run count and drive note = 0, octave = 0, note_valid = 0, with a note_changed pulse if the outputs were valid.
REQ-014 When the counter reaches TIMEOUT, the block SHALL disarm and clear candidate and outputs as in REQ-013.
REQ-015 Latency from the confirming tone_in edge to note_valid SHALL be 4 clk cycles: 2 synchronizer, 1 edge detect, 1 output register.
REQ-016 note_changed SHALL never be high for 2 consecutive cycles.

Reset
REQ-017 While rst = 1, synchronizer, counter, armed flag, candidate and run count SHALL clear, and outputs SHALL read note = 0, octave = 0, note_valid = 0, note_changed = 0.
REQ-018 rst asserted mid-measurement SHALL take effect on the next clk edge; the first tone_in edge after release only arms the measurement (REQ-005).

Configuration
REQ-019 With `TONE_DETECTOR_LOW_OCTAVE_EN` defined, both tables SHALL be compared.
REQ-020 Without `TONE_DETECTOR_LOW_OCTAVE_EN`, only the high table SHALL be compared, low-table periods are unmatched, and octave SHALL be constant 0.

Verification
REQ-021 Reset, then toggle tone_in every 37_923 cycles -> on the 5th edge + 4 cycles: note = 3, octave = 0, note_valid = 1, one-cycle note_changed.
REQ-022 Toggle every 38_436 cycles (TOL + 1 above mi) -> note_valid remains 0 indefinitely; every 38_435 cycles -> mi confirmed.
REQ-023 After mi is confirmed, hold tone_in constant -> 120_000 cycles after the last edge, note_valid = 0, note = 0, one note_changed pulse.
REQ-024 After mi is confirmed, switch to 35_794-cycle toggles -> note stays 3 through 3 fa periods, then becomes 4 after the 4th, with a single note_changed pulse.
REQ-025 Toggle every 101_239 cycles -> with the macro: note = 5, octave = 1, note_valid = 1; without the macro: note_valid stays 0.
REQ-026 Assert rst for 1 cycle at run count 3 -> all outputs 0 next cycle; confirmation afterwards needs 5 further edges.

Source files
------------

// File: rtl/tone_detector.sv
// -----------------------------------------------------------------------------
// tone_detector
//
// Recognises notes in a square-wave melody input by measuring the time between
// consecutive edges (one half-period) and comparing it against a table of
// reference half-periods. A note is declared only after CONFIRM consecutive
// matching half-periods. The output holds until another note is confirmed, an
// unmatched half-period arrives, or the input goes quiet for TIMEOUT cycles.
//
// Build option:
//   TONE_DETECTOR_LOW_OCTAVE_EN - when defined, the low-octave table is also
//   compared and octave can read 1. When undefined, only the high table is
//   used, low-table periods are unmatched and octave is constant 0.
//
// Parameters:
//   CONFIRM   - consecutive matching half-periods needed to declare a note
//   TOL       - inclusive +/- match window in clk cycles
//   TIMEOUT   - clk cycles without an edge before the tone counts as silent
//   REF_SHIFT - right shift applied to every reference half-period. Leave at 0
//               for the 50 MHz table; non-zero values run the same logic on
//               proportionally shorter tones.
//
// Ports:
//   clk          in   sole clock, 50 MHz
//   rst          in   synchronous active-high reset
//   tone_in      in   asynchronous square-wave input
//   note         out  0 none, 1 do, 2 re, 3 mi, 4 fa, 5 si
//   octave       out  0 high table, 1 low table
//   note_valid   out  a confirmed note is present
//   note_changed out  one-cycle pulse when {note_valid, note, octave} changes
//
// Timing: a tone_in edge reaches the outputs 4 clk cycles later
//   (2 synchronizer flops, 1 registered edge detect, 1 output register).
// -----------------------------------------------------------------------------
module tone_detector #(
  parameter int CONFIRM   = 4,
  parameter int TOL       = 512,
  parameter int TIMEOUT   = 120_000,
  parameter int REF_SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tone_in,
  output logic [2:0] note,
  output logic       octave,
  output logic       note_valid,
  output logic       note_changed
);

  localparam int RW = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);

  localparam logic [RW-1:0] CONFIRM_W  = RW'(CONFIRM);
  localparam logic [16:0]   TIMEOUT_C  = 17'(TIMEOUT);
  localparam logic [16:0]   TIMEOUT_M1 = 17'(TIMEOUT - 1);
  localparam logic [17:0]   TOL_W      = 18'(TOL);

  // Reference half-periods in table order do, re, mi, fa, si; the note code
  // reported for entry i is i + 1.
  localparam logic [16:0] HI_REF [5] = '{
    17'(47_779 >> REF_SHIFT),
    17'(42_567 >> REF_SHIFT),
    17'(37_923 >> REF_SHIFT),
    17'(35_794 >> REF_SHIFT),
    17'(50_620 >> REF_SHIFT)
  };

`ifdef TONE_DETECTOR_LOW_OCTAVE_EN
  localparam logic [16:0] LO_REF [5] = '{
    17'(95_557  >> REF_SHIFT),
    17'(85_132  >> REF_SHIFT),
    17'(75_844  >> REF_SHIFT),
    17'(71_588  >> REF_SHIFT),
    17'(101_239 >> REF_SHIFT)
  };
`endif

  // Inclusive window test |per - ref| <= TOL, done in 18 bits so that neither
  // side can wrap.
  function automatic logic in_win(input logic [16:0] per, input logic [16:0] ref_val);
    logic [17:0] p;
    logic [17:0] r;
    p = {1'b0, per};
    r = {1'b0, ref_val};
    return ((p + TOL_W) >= r) && (p <= (r + TOL_W));
  endfunction

  // ---------------------------------------------------------------------------
  // Synchronizer and registered edge detect
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic sync3;
  logic edge_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= tone_in;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 ^ sync3;
    end
  end

  // ---------------------------------------------------------------------------
  // Half-period counter. Restarts at 1 on each edge so that, at the next edge,
  // it holds exactly the number of cycles between the two edge pulses.
  // ---------------------------------------------------------------------------
  logic [16:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 17'd0;
    end else if (edge_q) begin
      cnt <= 17'd1;
    end else if (cnt < TIMEOUT_C) begin
      cnt <= cnt + 17'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Table match on the current count; first hit wins (windows are disjoint at
  // sensible TOL values anyway).
  // ---------------------------------------------------------------------------
  logic       m_hit;
  logic [2:0] m_note;
  logic       m_oct;

  always_comb begin
    m_hit  = 1'b0;
    m_note = 3'd0;
    m_oct  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!m_hit && in_win(cnt, HI_REF[i])) begin
        m_hit  = 1'b1;
        m_note = 3'(i + 1);
        m_oct  = 1'b0;
      end
    end
`ifdef TONE_DETECTOR_LOW_OCTAVE_EN
    for (int i = 0; i < 5; i++) begin
      if (!m_hit && in_win(cnt, LO_REF[i])) begin
        m_hit  = 1'b1;
        m_note = 3'(i + 1);
        m_oct  = 1'b1;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Candidate tracking and output update
  // ---------------------------------------------------------------------------
  logic          armed;
  logic [2:0]    cand_note;
  logic          cand_oct;
  logic [RW-1:0] run_cnt;

  logic          nxt_armed;
  logic [2:0]    nxt_cand_note;
  logic          nxt_cand_oct;
  logic [RW-1:0] nxt_run;
  logic [2:0]    nxt_note;
  logic          nxt_oct;
  logic          nxt_valid;
  logic          nxt_changed;
  logic          timeout_hit;

  // Fires on the cycle the counter steps onto TIMEOUT; disarming afterwards
  // keeps it from firing again while the counter sits saturated.
  assign timeout_hit = armed && !edge_q && (cnt == TIMEOUT_M1);

  always_comb begin
    nxt_armed     = armed;
    nxt_cand_note = cand_note;
    nxt_cand_oct  = cand_oct;
    nxt_run       = run_cnt;
    nxt_note      = note;
    nxt_oct       = octave;
    nxt_valid     = note_valid;

    if (edge_q) begin
      if (!armed) begin
        // First edge only starts the measurement.
        nxt_armed = 1'b1;
      end else if (m_hit) begin
        if ((run_cnt != '0) && (cand_note == m_note) && (cand_oct == m_oct)) begin
          if (run_cnt < CONFIRM_W) begin
            nxt_run = run_cnt + RW'(1);
          end
        end else begin
          nxt_cand_note = m_note;
          nxt_cand_oct  = m_oct;
          nxt_run       = RW'(1);
        end
        // Outputs only move once the candidate is confirmed; a confirmed
        // candidate equal to the current output reloads the same values.
        if (nxt_run == CONFIRM_W) begin
          nxt_note  = nxt_cand_note;
          nxt_oct   = nxt_cand_oct;
          nxt_valid = 1'b1;
        end
      end else begin
        nxt_cand_note = 3'd0;
        nxt_cand_oct  = 1'b0;
        nxt_run       = '0;
        nxt_note      = 3'd0;
        nxt_oct       = 1'b0;
        nxt_valid     = 1'b0;
      end
    end else if (timeout_hit) begin
      nxt_armed     = 1'b0;
      nxt_cand_note = 3'd0;
      nxt_cand_oct  = 1'b0;
      nxt_run       = '0;
      nxt_note      = 3'd0;
      nxt_oct       = 1'b0;
      nxt_valid     = 1'b0;
    end

    // Masking with the current pulse guarantees it is never two cycles long.
    nxt_changed = ({nxt_valid, nxt_note, nxt_oct} != {note_valid, note, octave})
                  && !note_changed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed        <= 1'b0;
      cand_note    <= 3'd0;
      cand_oct     <= 1'b0;
      run_cnt      <= '0;
      note         <= 3'd0;
      octave       <= 1'b0;
      note_valid   <= 1'b0;
      note_changed <= 1'b0;
    end else begin
      armed        <= nxt_armed;
      cand_note    <= nxt_cand_note;
      cand_oct     <= nxt_cand_oct;
      run_cnt      <= nxt_run;
      note         <= nxt_note;
      octave       <= nxt_oct;
      note_valid   <= nxt_valid;
      note_changed <= nxt_changed;
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_tone_detector
//
// Directed bench for tone_detector. The DUT runs with REF_SHIFT = 6, TOL = 8,
// TIMEOUT = 1875 so every reference half-period is the 50 MHz value >> 6:
//   high: do 746, re 665, mi 592, fa 559, si 790
//   low : do 1493, re 1330, mi 1185, fa 1118, si 1581
// A tone_in toggle made just after posedge N reaches the outputs right after
// posedge N+4. Timeout clears the outputs TIMEOUT+3 cycles after the last
// toggle (3 cycles to the detected edge, then TIMEOUT cycles of counting).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_detector;

  localparam int CONFIRM   = 4;
  localparam int TOL       = 8;
  localparam int TIMEOUT   = 1875;
  localparam int REF_SHIFT = 6;

  localparam int P_MI    = 592;
  localparam int P_FA    = 559;
  localparam int P_LO_SI = 1581;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tone_in = 1'b0;
  logic [2:0] note;
  logic       octave;
  logic       note_valid;
  logic       note_changed;

  always #5 clk = ~clk;

  tone_detector #(
    .CONFIRM   (CONFIRM),
    .TOL       (TOL),
    .TIMEOUT   (TIMEOUT),
    .REF_SHIFT (REF_SHIFT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .note         (note),
    .octave       (octave),
    .note_valid   (note_valid),
    .note_changed (note_changed)
  );

  // ---------------------------------------------------------------------------
  // Pulse bookkeeping
  // ---------------------------------------------------------------------------
  int   total = 0;
  int   bad   = 0;
  int   chg_cnt = 0;
  logic chg_prev = 1'b0;
  logic double_seen = 1'b0;
  int   base;

  always @(negedge clk) begin
    if (note_changed) chg_cnt++;
    if (note_changed && chg_prev) double_seen = 1'b1;
    chg_prev = note_changed;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle tone_in, then let p cycles pass before the next action.
  task automatic edge_wait(input int p);
    tone_in = ~tone_in;
    tick(p);
  endtask

  task automatic do_reset();
    tone_in = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state, sampled while rst is still high.
    tone_in = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_note",    32'(note), 0);
    chk("rst_octave",  32'(octave), 0);
    chk("rst_valid",   32'(note_valid), 0);
    chk("rst_changed", 32'(note_changed), 0);
    rst = 1'b0;
    tick(1);

    // Basic mi confirmation: edge 1 arms, edges 2..5 give four mi periods.
    base = chg_cnt;
    repeat (4) edge_wait(P_MI);
    chk("a_valid_after_4_edges", 32'(note_valid), 0);
    edge_wait(3);
    chk("a_valid_at_lat3", 32'(note_valid), 0);
    tick(1);
    chk("a_valid_at_lat4", 32'(note_valid), 1);
    chk("a_note",          32'(note), 3);
    chk("a_octave",        32'(octave), 0);
    chk("a_changed",       32'(note_changed), 1);
    tick(1);
    chk("a_changed_low",   32'(note_changed), 0);
    chk("a_pulse_count",   32'(chg_cnt - base), 1);

    // Silence: outputs clear TIMEOUT+3 cycles after the last toggle.
    base = chg_cnt;
    tick(TIMEOUT + 2 - 5);
    chk("b_valid_before_to", 32'(note_valid), 1);
    tick(1);
    chk("b_valid_after_to",  32'(note_valid), 0);
    chk("b_note_after_to",   32'(note), 0);
    chk("b_changed_to",      32'(note_changed), 1);
    tick(1);
    chk("b_changed_to_low",  32'(note_changed), 0);
    chk("b_pulse_count",     32'(chg_cnt - base), 1);

    // mi confirmed again after the timeout, then fa takes over after 4 periods.
    repeat (4) edge_wait(P_MI);
    edge_wait(4);
    chk("c_mi_valid", 32'(note_valid), 1);
    chk("c_mi_note",  32'(note), 3);
    tick(P_FA - 4);
    base = chg_cnt;
    repeat (3) edge_wait(P_FA);
    chk("c_note_after_3fa", 32'(note), 3);
    edge_wait(3);
    chk("c_note_at_lat3",   32'(note), 3);
    tick(1);
    chk("c_note_fa",        32'(note), 4);
    chk("c_valid_fa",       32'(note_valid), 1);
    chk("c_changed_fa",     32'(note_changed), 1);
    tick(1);
    chk("c_pulse_count",    32'(chg_cnt - base), 1);

    // Reset at run count 3 of a pending fa candidate while mi is shown.
    do_reset();
    repeat (4) edge_wait(P_MI);
    repeat (3) edge_wait(P_FA);
    edge_wait(10);
    chk("g_note_pre_rst",  32'(note), 3);
    chk("g_valid_pre_rst", 32'(note_valid), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("g_note_rst",    32'(note), 0);
    chk("g_octave_rst",  32'(octave), 0);
    chk("g_valid_rst",   32'(note_valid), 0);
    chk("g_changed_rst", 32'(note_changed), 0);
    repeat (4) edge_wait(P_MI);
    chk("g_valid_after_4", 32'(note_valid), 0);
    edge_wait(4);
    chk("g_valid_after_5", 32'(note_valid), 1);
    chk("g_note_after_5",  32'(note), 3);

    // Just outside the window above mi: never confirms.
    do_reset();
    repeat (6) edge_wait(P_MI + TOL + 1);
    chk("d_valid_above_tol", 32'(note_valid), 0);

    // Just outside the window below mi: never confirms.
    do_reset();
    repeat (6) edge_wait(P_MI - TOL - 1);
    chk("e_valid_below_tol", 32'(note_valid), 0);

    // Upper edge of the window confirms mi; an unmatched period then clears it.
    do_reset();
    repeat (4) edge_wait(P_MI + TOL);
    edge_wait(4);
    chk("d_valid_at_tol", 32'(note_valid), 1);
    chk("d_note_at_tol",  32'(note), 3);
    tick(700 - 4);
    base = chg_cnt;
    edge_wait(3);
    chk("d_valid_pre_clear", 32'(note_valid), 1);
    tick(1);
    chk("d_valid_unmatched",   32'(note_valid), 0);
    chk("d_note_unmatched",    32'(note), 0);
    chk("d_changed_unmatched", 32'(note_changed), 1);
    tick(1);
    chk("d_pulse_count", 32'(chg_cnt - base), 1);

    // Low-table si.
    do_reset();
    repeat (4) edge_wait(P_LO_SI);
    edge_wait(4);
`ifdef TONE_DETECTOR_LOW_OCTAVE_EN
    chk("f_lo_si_valid",  32'(note_valid), 1);
    chk("f_lo_si_note",   32'(note), 5);
    chk("f_lo_si_octave", 32'(octave), 1);
`else
    chk("f_lo_si_valid",  32'(note_valid), 0);
    chk("f_lo_si_note",   32'(note), 0);
    chk("f_lo_si_octave", 32'(octave), 0);
`endif

    chk("no_double_pulse", 32'(double_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
